// File: rtl/asic_isoseq.sv
// -----------------------------------------------------------------------------
// asic_isoseq
//   Power-domain isolation sequencer with an N-bit clamp bank. Lives in the
//   always-on domain between the power manager and a switchable domain.
//   Isolation is raised before the power switch opens. It is held until the
//   rail reports good and a programmable settle time has elapsed.
//
// Parameters
//   N      width of the isolated data bus
//   CW     width of the delay counter and of the delay configuration inputs
//   CLAMP  "HIGH": out = iso | in      "LOW": out = ~iso & in
//   PROP   technology hint for downstream flows; no functional effect
//
// Ports
//   clk        always-on clock
//   nreset     synchronous active-low reset
//   sleep_req  1 = request power-down, 0 = request power-up
//   iso_dly    ISOLATE dwell minus one (sampled on counter load)
//   pwr_dly    SETTLE dwell minus one (sampled on counter load)
//   pwr_good   switchable rail stable, already synchronised to clk
//   in         signals arriving from the switchable domain
//   out        clamped signals towards the always-on domain
//   iso        registered isolation enable
//   pwr_en     registered power-switch enable
//   sleep_ack  high only while the domain is safely off
//   busy       high while a transition is in progress
// -----------------------------------------------------------------------------
module asic_isoseq #(
    parameter int    N     = 1,
    parameter int    CW    = 8,
    parameter string CLAMP = "HIGH",
    parameter string PROP  = "DEFAULT"
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          sleep_req,
    input  logic [CW-1:0] iso_dly,
    input  logic [CW-1:0] pwr_dly,
    input  logic          pwr_good,
    input  logic [N-1:0]  in,
    output logic [N-1:0]  out,
    output logic          iso,
    output logic          pwr_en,
    output logic          sleep_ack,
    output logic          busy
);

    typedef enum logic [2:0] {
        ST_ON      = 3'd0,
        ST_ISOLATE = 3'd1,
        ST_OFF     = 3'd2,
        ST_WAKE    = 3'd3,
        ST_SETTLE  = 3'd4
    } state_t;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          iso_r;
    logic          pwr_en_r;
    logic          sleep_ack_r;
    logic          busy_r;
    logic          iso_nxt_s;
    logic          pwr_en_nxt_s;
    logic          sleep_ack_nxt_s;
    logic          busy_nxt_s;

    // Next-state and counter logic. Within each state the checks run in
    // priority order. A sleep_req reversal always wins over counter expiry.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_ON: begin
                if (sleep_req) begin
                    state_nxt_s = ST_ISOLATE;
                    cnt_nxt_s   = iso_dly;
                end else begin
                    state_nxt_s = ST_ON;
                end
            end
            ST_ISOLATE: begin
                if (!sleep_req) begin
                    // Abort: power was never removed, so release at once.
                    state_nxt_s = ST_ON;
                end else if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_OFF;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_OFF: begin
                if (!sleep_req) begin
                    state_nxt_s = ST_WAKE;
                end else begin
                    state_nxt_s = ST_OFF;
                end
            end
            ST_WAKE: begin
                if (sleep_req) begin
                    state_nxt_s = ST_OFF;
                end else if (pwr_good) begin
                    state_nxt_s = ST_SETTLE;
                    cnt_nxt_s   = pwr_dly;
                end else begin
                    state_nxt_s = ST_WAKE;
                end
            end
            ST_SETTLE: begin
                if (sleep_req) begin
                    state_nxt_s = ST_OFF;
                end else if (!pwr_good) begin
                    // A rail glitch restarts the whole settle period.
                    state_nxt_s = ST_WAKE;
                end else if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_ON;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_OFF;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Decode the outputs from the next state, so the registered outputs
    // line up with the state register and have no input-to-output path.
    always_comb begin
        iso_nxt_s       = 1'b1;
        pwr_en_nxt_s    = 1'b1;
        sleep_ack_nxt_s = 1'b0;
        busy_nxt_s      = 1'b0;
        case (state_nxt_s)
            ST_ON: begin
                iso_nxt_s = 1'b0;
            end
            ST_OFF: begin
                pwr_en_nxt_s    = 1'b0;
                sleep_ack_nxt_s = 1'b1;
            end
            ST_ISOLATE, ST_WAKE, ST_SETTLE: begin
                busy_nxt_s = 1'b1;
            end
            default: begin
                pwr_en_nxt_s    = 1'b0;
                sleep_ack_nxt_s = 1'b1;
            end
        endcase
    end

    // State, counter and output registers. Reset lands directly in OFF.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r     <= ST_OFF;
            cnt_r       <= CNT_ZERO;
            iso_r       <= 1'b1;
            pwr_en_r    <= 1'b0;
            sleep_ack_r <= 1'b1;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            iso_r       <= iso_nxt_s;
            pwr_en_r    <= pwr_en_nxt_s;
            sleep_ack_r <= sleep_ack_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign iso       = iso_r;
    assign pwr_en    = pwr_en_r;
    assign sleep_ack = sleep_ack_r;
    assign busy      = busy_r;

    // Clamp bank: zero-latency gating of the crossing bus by registered iso.
    generate
        if (CLAMP == "LOW") begin : g_clamp_low
            assign out = ~{N{iso_r}} & in;
        end else begin : g_clamp_high
            assign out = {N{iso_r}} | in;
        end
    endgenerate

    // Hook point for technology-specific isolation cells. The generic
    // clamp logic above is used for every value of PROP.
    generate
        if (PROP != "DEFAULT") begin : g_prop_custom
        end
    endgenerate

endmodule

// File: tb/tb_asic_isoseq.sv
module tb_asic_isoseq;

    logic       clk = 1'b0;
    logic       nreset;
    logic       sleep_req;
    logic [7:0] iso_dly;
    logic [7:0] pwr_dly;
    logic       pwr_good;
    logic [7:0] din;
    logic [7:0] out_h, out_l;
    logic       iso_h, pwr_en_h, ack_h, busy_h;
    logic       iso_l, pwr_en_l, ack_l, busy_l;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    asic_isoseq #(.N(8), .CW(8), .CLAMP("HIGH"), .PROP("DEFAULT")) dut_h (
        .clk(clk), .nreset(nreset), .sleep_req(sleep_req), .iso_dly(iso_dly),
        .pwr_dly(pwr_dly), .pwr_good(pwr_good), .in(din), .out(out_h),
        .iso(iso_h), .pwr_en(pwr_en_h), .sleep_ack(ack_h), .busy(busy_h)
    );

    asic_isoseq #(.N(8), .CW(8), .CLAMP("LOW"), .PROP("DEFAULT")) dut_l (
        .clk(clk), .nreset(nreset), .sleep_req(sleep_req), .iso_dly(iso_dly),
        .pwr_dly(pwr_dly), .pwr_good(pwr_good), .in(din), .out(out_l),
        .iso(iso_l), .pwr_en(pwr_en_l), .sleep_ack(ack_l), .busy(busy_l)
    );

    // Reference model: phase plus elapsed-cycles versus required dwell.
    localparam int M_ON = 0, M_ISO = 1, M_OFF = 2, M_WAKE = 3, M_SETTLE = 4;
    int m_mode    = M_OFF;
    int m_elapsed = 0;
    int m_need    = 0;

    task automatic model_step();
        if (!nreset) begin
            m_mode = M_OFF;
        end else begin
            case (m_mode)
                M_ON: if (sleep_req) begin
                    m_mode = M_ISO; m_elapsed = 0; m_need = int'(iso_dly) + 1;
                end
                M_ISO: if (!sleep_req) m_mode = M_ON;
                       else begin
                           m_elapsed++;
                           if (m_elapsed == m_need) m_mode = M_OFF;
                       end
                M_OFF: if (!sleep_req) m_mode = M_WAKE;
                M_WAKE: if (sleep_req) m_mode = M_OFF;
                        else if (pwr_good) begin
                            m_mode = M_SETTLE; m_elapsed = 0; m_need = int'(pwr_dly) + 1;
                        end
                M_SETTLE: if (sleep_req) m_mode = M_OFF;
                          else if (!pwr_good) m_mode = M_WAKE;
                          else begin
                              m_elapsed++;
                              if (m_elapsed == m_need) m_mode = M_ON;
                          end
                default: m_mode = M_OFF;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        logic e_iso, e_pwr, e_ack, e_busy;
        e_iso  = (m_mode != M_ON);
        e_pwr  = (m_mode != M_OFF);
        e_ack  = (m_mode == M_OFF);
        e_busy = (m_mode == M_ISO) || (m_mode == M_WAKE) || (m_mode == M_SETTLE);
        chk("iso_h",    {7'd0, iso_h},    {7'd0, e_iso});
        chk("iso_l",    {7'd0, iso_l},    {7'd0, e_iso});
        chk("pwr_en_h", {7'd0, pwr_en_h}, {7'd0, e_pwr});
        chk("pwr_en_l", {7'd0, pwr_en_l}, {7'd0, e_pwr});
        chk("ack",      {7'd0, ack_h},    {7'd0, e_ack});
        chk("busy",     {7'd0, busy_h},   {7'd0, e_busy});
        chk("out_high", out_h, e_iso ? 8'hFF : din);
        chk("out_low",  out_l, e_iso ? 8'h00 : din);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    task automatic go_on();
        sleep_req = 1'b0; pwr_good = 1'b1; pwr_dly = 8'd0;
        for (int i = 0; i < 30; i++) begin
            if (m_mode == M_ON && iso_h === 1'b0) break;
            tick();
        end
        chk("reach_on", {7'd0, iso_h}, 8'd0);
    endtask

    initial begin
        int n;
        nreset = 1'b0; sleep_req = 1'b0; iso_dly = 8'd4; pwr_dly = 8'd2;
        pwr_good = 1'b0; din = 8'h5A;

        // Reset state
        tick(); tick();
        chk("rst_iso", {7'd0, iso_h}, 8'd1);
        chk("rst_pwr_en", {7'd0, pwr_en_h}, 8'd0);
        chk("rst_ack", {7'd0, ack_h}, 8'd1);
        chk("rst_busy", {7'd0, busy_h}, 8'd0);

        // Test 1: wake, pwr_good after 3 cycles, settle of 3 cycles
        nreset = 1'b1;
        tick();
        chk("t1_busy_wake", {7'd0, busy_h}, 8'd1);
        tick(); tick();
        pwr_good = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (iso_h === 1'b0) break;
        end
        chk("t1_settle_len", n[7:0], 8'd3);
        din = 8'hC3; #1;
        chk("t1_out_pass", out_h, 8'hC3);

        // Test 2: iso_dly=4, power drops exactly 5 cycles after iso rises
        sleep_req = 1'b1; iso_dly = 8'd4;
        tick();
        chk("t2_iso_up", {7'd0, iso_h}, 8'd1);
        chk("t2_clamp_high", out_h, 8'hFF);
        chk("t2_clamp_low", out_l, 8'h00);
        iso_dly = 8'd0;  // must be ignored after the load
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (pwr_en_h === 1'b0) break;
        end
        chk("t2_iso_dwell", n[7:0], 8'd5);
        chk("t2_ack", {7'd0, ack_h}, 8'd1);

        // Test 3: abort in ISOLATE
        go_on();
        iso_dly = 8'd10; sleep_req = 1'b1;
        tick(); tick(); tick(); tick();
        sleep_req = 1'b0;
        tick();
        chk("t3_iso_release", {7'd0, iso_h}, 8'd0);
        chk("t3_pwr_kept", {7'd0, pwr_en_h}, 8'd1);

        // Test 4: rail glitch in SETTLE restarts the full settle
        sleep_req = 1'b1; iso_dly = 8'd0;
        tick(); tick();
        chk("t4_off", {7'd0, ack_h}, 8'd1);
        sleep_req = 1'b0; pwr_good = 1'b1; pwr_dly = 8'd5;
        tick(); tick(); tick();
        pwr_good = 1'b0;
        tick();
        chk("t4_glitch_iso", {7'd0, iso_h}, 8'd1);
        chk("t4_glitch_busy", {7'd0, busy_h}, 8'd1);
        pwr_good = 1'b1;
        tick();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick(); n++;
            if (iso_h === 1'b0) break;
        end
        chk("t4_settle_len", n[7:0], 8'd6);

        // Test 5: zero delays, one-cycle dwells
        iso_dly = 8'd0; pwr_dly = 8'd0; sleep_req = 1'b1;
        tick(); tick();
        chk("t5_off", {7'd0, ack_h}, 8'd1);
        sleep_req = 1'b0;
        tick(); tick(); tick();
        chk("t5_on", {7'd0, iso_h}, 8'd0);

        // Random phase against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) sleep_req = ~sleep_req;
            pwr_good = ($urandom_range(0, 7) != 0);
            iso_dly  = 8'($urandom_range(0, 6));
            pwr_dly  = 8'($urandom_range(0, 6));
            din      = 8'($urandom);
            nreset   = ($urandom_range(0, 149) != 0);
            tick();
        end
        nreset = 1'b1;

        // Test 6: reset mid-ISOLATE, LOW clamp behaviour
        go_on();
        din = 8'hA5; #1;
        chk("t6_low_pass", out_l, 8'hA5);
        sleep_req = 1'b1; iso_dly = 8'd10;
        tick(); tick();
        chk("t6_low_clamp", out_l, 8'h00);
        nreset = 1'b0;
        tick();
        chk("t6_rst_ack", {7'd0, ack_h}, 8'd1);
        chk("t6_rst_pwr_en", {7'd0, pwr_en_l}, 8'd0);
        chk("t6_rst_busy", {7'd0, busy_l}, 8'd0);
        nreset = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
